// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: FSM state codes, parity
// type constants, output mux selects and the parity-bit helper.
package uart_tx_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [1:0] {
        SEL_START  = 2'd0,
        SEL_DATA   = 2'd1,
        SEL_PARITY = 2'd2,
        SEL_STOP   = 2'd3
    } tx_sel_e;

    // Even parity is the XOR of the payload, odd parity is its complement.
    function automatic logic parityBit(input logic dataXor, input logic parTyp);
        return (parTyp == PAR_ODD) ? ~dataXor : dataXor;
    endfunction

endpackage

// File: rtl/uart_tx_serializer.sv
// Payload shift register for the UART transmitter: loads a word on accept,
// shifts it out LSB first and tracks the bit position and word parity.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  clck,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_shift,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_bit,
    output logic [CNT_W-1:0]      o_bitCnt,
    output logic                  o_serDone,
    output logic                  o_parity
);

    logic [DATA_WIDTH-1:0] r_shift;
    logic [CNT_W-1:0]      r_bitCnt;
    logic                  r_parity;

    // Parity is captured at load time so later shifting cannot disturb it.
    always_ff @(posedge clck or negedge rst) begin
        if (!rst) begin
            r_shift  <= '0;
            r_bitCnt <= '0;
            r_parity <= 1'b0;
        end else if (i_load) begin
            r_shift  <= i_data;
            r_bitCnt <= '0;
            r_parity <= ^i_data;
        end else if (i_shift) begin
            r_shift  <= {1'b0, r_shift[DATA_WIDTH-1:1]};
            r_bitCnt <= o_serDone ? r_bitCnt : r_bitCnt + 1'b1;
        end
    end

    assign o_bit     = r_shift[0];
    assign o_bitCnt  = r_bitCnt;
    assign o_serDone = (r_bitCnt == CNT_W'(DATA_WIDTH - 1));
    assign o_parity  = r_parity;

endmodule

// File: rtl/uart_tx_gen.sv
// UART transmitter top: frame FSM, latched frame configuration and the
// output mux; one serial bit per clck cycle, back-to-back capable.
module uart_tx_gen
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
    parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                  clck,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] p_data,
    input  logic                  data_valid,
    input  logic                  par_en,
    input  logic                  par_typ,
    output logic                  tx_out,
    output logic                  busy,
    output logic                  data_ack
);

    logic [2:0]       r_state;
    logic [2:0]       w_nextState;
    logic             r_parEn;
    logic             r_parTyp;
    logic             r_dataAck;
    logic             r_stopCnt;
    logic             w_lastStop;
    logic             w_accept;
    logic             w_serBit;
    logic             w_serDone;
    logic             w_serParity;
    logic [CNT_W-1:0] w_unusedBitCnt;
    tx_sel_e          w_sel;

    uart_tx_serializer #(
        .DATA_WIDTH (DATA_WIDTH),
        .CNT_W      (CNT_W)
    ) u_serializer (
        .clck      (clck),
        .rst       (rst),
        .i_load    (w_accept),
        .i_shift   (r_state == ST_DATA),
        .i_data    (p_data),
        .o_bit     (w_serBit),
        .o_bitCnt  (w_unusedBitCnt),
        .o_serDone (w_serDone),
        .o_parity  (w_serParity)
    );

    // A new word may be taken while idle or on the last stop cycle, which is
    // what lets frames run back to back without an idle gap.
    assign w_lastStop = (r_state == ST_STOP) && (r_stopCnt == 1'(STOP_BITS - 1));
    assign w_accept   = data_valid && ((r_state == ST_IDLE) || w_lastStop);

    always_comb begin
        w_nextState = ST_IDLE;
        case (r_state)
            ST_IDLE:   w_nextState = w_accept ? ST_START : ST_IDLE;
            ST_START:  w_nextState = ST_DATA;
            ST_DATA:   w_nextState = w_serDone ? (r_parEn ? ST_PARITY : ST_STOP) : ST_DATA;
            ST_PARITY: w_nextState = ST_STOP;
            ST_STOP:   w_nextState = w_lastStop ? (w_accept ? ST_START : ST_IDLE) : ST_STOP;
            default:   w_nextState = ST_IDLE;
        endcase
    end

    always_ff @(posedge clck or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_parEn   <= 1'b0;
            r_parTyp  <= PAR_EVEN;
            r_dataAck <= 1'b0;
            r_stopCnt <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_dataAck <= w_accept;
            r_stopCnt <= ((r_state == ST_STOP) && !w_lastStop) ? r_stopCnt + 1'b1 : 1'b0;
            if (w_accept) begin
                r_parEn  <= par_en;
                r_parTyp <= par_typ;
            end
        end
    end

    // Output decode uses registered state only; unknown states drive the line high.
    always_comb begin
        w_sel = SEL_STOP;
        case (r_state)
            ST_START:  w_sel = SEL_START;
            ST_DATA:   w_sel = SEL_DATA;
            ST_PARITY: w_sel = SEL_PARITY;
            default:   w_sel = SEL_STOP;
        endcase
    end

    always_comb begin
        tx_out = 1'b1;
        case (w_sel)
            SEL_START:  tx_out = 1'b0;
            SEL_DATA:   tx_out = w_serBit;
            SEL_PARITY: tx_out = parityBit(w_serParity, r_parTyp);
            default:    tx_out = 1'b1;
        endcase
    end

    assign busy     = (r_state == ST_START) || (r_state == ST_DATA) ||
                      (r_state == ST_PARITY) || (r_state == ST_STOP);
    assign data_ack = r_dataAck;

endmodule

// File: doc/uart_tx_gen.md
Name: uart_tx_gen

Overview:
Parametrised UART transmitter: FSM, serializer, parity generator and output mux in one block. Frame width, stop-bit count and parity type are configurable. Supports back-to-back frames with no idle gap. Runs on the bit-rate clock (one bit per clck cycle) and sits between the system data source and the serial TX pin.

Parameters:
DATA_WIDTH, 8, payload bits per frame (legal 5..9)
STOP_BITS, 1, stop bits per frame (legal 1 or 2)
CNT_W, $clog2(DATA_WIDTH), bit-counter width (derived, not overridden)

Ports:
clck  input  1  bit-rate clock, rising edge
rst  input  1  asynchronous active-low reset
p_data  input  DATA_WIDTH  parallel payload, sampled only on acceptance
data_valid  input  1  payload request
par_en  input  1  1 = parity bit inserted; sampled on acceptance
par_typ  input  1  0 = even, 1 = odd; sampled on acceptance
tx_out  output  1  serial line, idle high
busy  output  1  high from START through the last STOP cycle
data_ack  output  1  one-cycle pulse: payload accepted on this edge

Behaviour:
- Reset (async, rst=0): state IDLE, tx_out=1, busy=0, data_ack=0, shift register, bit counter and latched config cleared. Applies immediately mid-frame; the partial frame is abandoned and is not resumed after reset release.
- States: IDLE, START, DATA, PARITY, STOP.
- Acceptance: on a clck edge where data_valid=1 and (state=IDLE, or state=STOP on its final stop cycle). At that edge:
  - p_data, par_en and par_typ are latched.
  - State goes to START.
  - data_ack is registered high for exactly one cycle, coincident with the START cycle.
- data_valid in any other state or cycle is ignored. There is no queueing; the source must hold data_valid until data_ack.
- START: 1 cycle, tx_out=0.
- DATA: DATA_WIDTH cycles, LSB first; bit counter runs 0..DATA_WIDTH-1.
  - Exit to PARITY if latched par_en=1, else to STOP.
- PARITY: 1 cycle.
  - tx_out = XOR of latched data when even.
  - tx_out = inverted XOR when odd.
- STOP: STOP_BITS cycles, tx_out=1.
  - After the final stop cycle: START if accepted, else IDLE.
- IDLE: tx_out=1, busy=0.
- Frame length: 1 + DATA_WIDTH + par_en + STOP_BITS cycles. busy is high for exactly that many cycles per frame.
- Back-to-back frames: busy stays high continuously; no IDLE cycle is inserted between frames.
- tx_out, busy and data_ack are functions of registered state only; there is no combinational path from any input to any output.
- Changes to p_data, par_en or par_typ mid-frame have no effect on the frame in flight.
- Illegal or unused state encodings recover to IDLE on the next edge with tx_out=1.

Decomposition:
- Shared package uart_tx_pkg:
  - State encoding localparams (3-bit).
  - Parity-type constants PAR_EVEN=0, PAR_ODD=1.
  - Mux-select encoding for start/stop/data/parity.
- One sub-module, uart_tx_serializer:
  - Parametrised by DATA_WIDTH.
  - Loads on accept and shifts while in DATA.
  - Provides the current bit, the bit counter, a ser_done flag on the last data bit, and the parity of the loaded word.
- The top level holds the FSM, config latches and the output mux.

Test Plan:
1. Assert rst=0 for 3 cycles, then release -> tx_out=1, busy=0, data_ack=0 throughout and after release; remains idle while data_valid=0.
2. Default params, p_data=0xA5, par_en=0, one-cycle data_valid -> data_ack pulse; tx_out = 0,1,0,1,0,0,1,0,1,1; busy high exactly 10 cycles; then IDLE.
3. p_data=0xA5, par_en=1:
   - par_typ=0 -> parity bit 0, 11-cycle frame.
   - Repeat with par_typ=1 -> parity bit 1.
4. data_valid held high with 0x0F then 0xF0 -> second start bit in the cycle right after the first stop bit; busy never drops; two data_ack pulses 10 cycles apart.
5. Change p_data, par_en and par_typ during DATA bit 3 -> current frame unchanged; new values apply only to the next accepted frame.
6. DATA_WIDTH=7, STOP_BITS=2, p_data=0x55, par_en=1, par_typ=1 -> 0,1,0,1,0,1,0,1,1,1,1 (parity 1), 11 cycles. A separate run asserts rst=0 during data bit 4 -> tx_out=1 and busy=0 immediately.
